resq_dispatcher: RTL
====================

// Module: resq_dispatcher
// PURPOSE
//  Consumer/serve-side controller for the relief queue manager. Watches the queue status flags
//  and muxed head (Output_Zone/Output_Priority), assigns each pending request to a free field
//  team, and pulses Serve back into the queue manager to pop it. Sits between the queue manager
//  and the dispatch/telemetry logic. Tracks per-team service countdowns and a dispatch counter.
// PARAMETERS
//  NUM_TEAMS     4   number of field teams (1..8)
//  EVAC_CYCLES   8   base service time for evacuation dispatches
//  RELIEF_CYCLES 4   base service time for food/shelter dispatches
//  TIMER_W       5   per-team countdown width; EVAC_CYCLES+3 must fit
// PORTS
//  Clock           in   1          system clock, rising edge
//  Reset_Queue     in   1          asynchronous, active-high reset
//  Enable          in   1          1 = dispatching allowed; sampled in S_IDLE only
//  Evac_Empty      in   1          evac FIFO empty (from queue manager)
//  Shelter_Valid   in   1          shelter queue has a valid winner
//  Food_Valid      in   1          food queue has a valid winner
//  Output_Zone     in   8          zone at head of queue-manager output mux
//  Output_Priority in   2          priority at head of queue-manager output mux
//  Serve           out  1          1-cycle pop pulse to queue manager
//  Dispatch_Valid  out  1          1-cycle strobe, concurrent with Serve
//  Dispatch_Zone   out  8          zone latched for this dispatch (held until next dispatch)
//  Dispatch_Type   out  2          00 food, 01 shelter, 10 evac, 11 relief-mixed (held)
//  Dispatch_Team   out  3          team index assigned (held)
//  Team_Busy       out  NUM_TEAMS  bit i = 1 while team i timer != 0
//  Dispatch_Count  out  8          total dispatches, wraps 255->0
// BEHAVIOUR
//  - Reset (async): state S_IDLE; every output and all team timers = 0.
//  - Pending = !Evac_Empty | Shelter_Valid | Food_Valid. Free team = timer == 0.
//  - FSM: S_IDLE -> S_SERVE -> S_SETTLE -> S_IDLE.
//    S_IDLE: if Enable & Pending & any free team: latch Dispatch_Zone=Output_Zone,
//      Dispatch_Type, Dispatch_Team = lowest-index free team, load that team's timer,
//      Dispatch_Count+1; go S_SERVE. Otherwise stay.
//    S_SERVE: Serve=1, Dispatch_Valid=1 (registered, exactly this one cycle); go S_SETTLE.
//    S_SETTLE: outputs idle one cycle so queue flags/head update after the pop; go S_IDLE.
//    => minimum 3 cycles between Serve pulses; first Serve 1 cycle after the qualifying S_IDLE edge.
//  - Type decode (at latch): !Evac_Empty -> 10; else Shelter_Valid&!Food_Valid -> 01;
//    Food_Valid&!Shelter_Valid -> 00; both valid -> 11.
//  - Timer load = (type==10 ? EVAC_CYCLES : RELIEF_CYCLES) + Output_Priority (zero-extended).
//  - Timers of busy teams decrement by 1 every cycle; a team loaded this cycle does not decrement.
//    Team with timer==1 is not free this cycle; it becomes free (timer 0) the next cycle.
//  - All teams busy: stay S_IDLE, no Serve, request remains queued (no drop).
//  - Enable low in S_SERVE/S_SETTLE: sequence completes; blocks next dispatch only.
//  - Pending drops during S_SERVE (external cancel): Serve still issued; queue manager ignores
//    pops on empty. Latched values reflect the sampled head.
//  - Reset mid-sequence: Serve/Dispatch_Valid fall immediately; all teams freed; count = 0.
// TESTING
//  1. Assert Reset_Queue 2 cycles, release -> all outputs 0, Team_Busy=0000, no Serve.
//  2. Enable=1, Evac_Empty=0, Zone=8'd12, Prio=01 -> Serve 1 cycle, Type=10, Team=0,
//     Team_Busy=0001, team 0 timer=9; Team_Busy[0] clears 9 cycles after load; Count=1.
//  3. Food_Valid=1 only, Zone=8'd15, Prio=10 -> Type=00, timer=6; with Shelter_Valid also 1 -> Type=11.
//  4. Keep requests pending with 4 teams busy -> no Serve until a timer hits 0; next dispatch
//     uses the lowest freed index; Serve pulses never closer than 3 cycles.
//  5. Enable=0 with pending requests -> no Serve; raise Enable -> Serve within 2 cycles.
//  6. Assert Reset_Queue during S_SERVE -> Serve falls without a clock edge; Team_Busy=0, Count=0.

Source files
------------

// File: rtl/resq_dispatcher.sv
// rtl/resq_dispatcher.sv - serve-side controller: pops pending relief requests and assigns them to free field teams
module resq_dispatcher #(
   parameter int NUM_TEAMS     = 4,
   parameter int EVAC_CYCLES   = 8,
   parameter int RELIEF_CYCLES = 4,
   parameter int TIMER_W       = 5
) (
   input  logic                 Clock,
   input  logic                 Reset_Queue,
   input  logic                 Enable,
   input  logic                 Evac_Empty,
   input  logic                 Shelter_Valid,
   input  logic                 Food_Valid,
   input  logic [7:0]           Output_Zone,
   input  logic [1:0]           Output_Priority,
   output logic                 Serve,
   output logic                 Dispatch_Valid,
   output logic [7:0]           Dispatch_Zone,
   output logic [1:0]           Dispatch_Type,
   output logic [2:0]           Dispatch_Team,
   output logic [NUM_TEAMS-1:0] Team_Busy,
   output logic [7:0]           Dispatch_Count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SERVE  = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   logic [1:0]         state;
   logic [TIMER_W-1:0] timer [NUM_TEAMS];
   logic               pending;
   logic               any_free;
   logic [2:0]         free_idx;
   logic [1:0]         type_dec;
   logic [TIMER_W-1:0] load_val;
   logic               start;

   assign pending = !Evac_Empty | Shelter_Valid | Food_Valid;

   // Descending scan so the lowest-index free team is the one left selected.
   always_comb begin
      any_free = 1'b0;
      free_idx = 3'd0;
      for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
         if (timer[i] == '0) begin
            any_free = 1'b1;
            free_idx = 3'(i);
         end
      end
   end

   always_comb begin
      type_dec = 2'b11;
      if (!Evac_Empty)
         type_dec = 2'b10;
      else if (Shelter_Valid && !Food_Valid)
         type_dec = 2'b01;
      else if (Food_Valid && !Shelter_Valid)
         type_dec = 2'b00;
   end

   assign load_val = ((type_dec == 2'b10) ? TIMER_W'(EVAC_CYCLES) : TIMER_W'(RELIEF_CYCLES))
                     + TIMER_W'(Output_Priority);

   assign start = (state == S_IDLE) && Enable && pending && any_free;

   always_comb begin
      Team_Busy = '0;
      for (int i = 0; i < NUM_TEAMS; i++)
         Team_Busy[i] = (timer[i] != '0);
   end

   // A team loaded this cycle takes the new value instead of decrementing.
   always_ff @(posedge Clock or posedge Reset_Queue) begin
      if (Reset_Queue) begin
         for (int i = 0; i < NUM_TEAMS; i++)
            timer[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_TEAMS; i++) begin
            if (start && (free_idx == 3'(i)))
               timer[i] <= load_val;
            else if (timer[i] != '0)
               timer[i] <= timer[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset_Queue) begin
      if (Reset_Queue) begin
         state          <= S_IDLE;
         Serve          <= 1'b0;
         Dispatch_Valid <= 1'b0;
         Dispatch_Zone  <= 8'd0;
         Dispatch_Type  <= 2'b00;
         Dispatch_Team  <= 3'd0;
         Dispatch_Count <= 8'd0;
      end else begin
         Serve          <= 1'b0;
         Dispatch_Valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  Dispatch_Zone  <= Output_Zone;
                  Dispatch_Type  <= type_dec;
                  Dispatch_Team  <= free_idx;
                  Dispatch_Count <= Dispatch_Count + 8'd1;
                  Serve          <= 1'b1;
                  Dispatch_Valid <= 1'b1;
                  state          <= S_SERVE;
               end
            end
            S_SERVE:  state <= S_SETTLE;
            S_SETTLE: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule
